// File: rtl/alu_pkg.sv
// Shared ALU definitions: CPU word width, divider state encoding and
// the step-counter width helper.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divState_e;

    // The counter must be able to hold WIDTH itself, hence the extra bit.
    function automatic int cntWidth(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int STEP_CNT_W = cntWidth(WIDTH_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, keeping the difference only when no borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   remNext,
    output logic             qBit
);

    logic [WIDTH:0] diff;

    // Borrow out of the top bit means the divisor did not fit.
    always_comb begin
        diff    = t - {1'b0, divisor};
        qBit    = ~diff[WIDTH];
        remNext = qBit ? diff : t;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; divide-by-zero is resolved here directly
// CALC  | one shift-and-trial-subtract step per edge, WIDTH steps total
// DONE  | results valid, done pulses for one cycle, then back to IDLE
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             dz
);

    localparam int CNT_W = cntWidth(WIDTH);

    divState_e        state;
    divState_e        nextState;
    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH:0]   remReg;
    logic [CNT_W-1:0] stepCnt;

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   remNext;
    logic             qBit;
    logic             lastStep;

    // Shift the partial remainder left, pulling in the next dividend bit.
    // The remainder's top bit is always zero after a step, so it falls off.
    assign t        = (WIDTH+1)'({remReg, qReg[WIDTH-1]});
    assign lastStep = (stepCnt == CNT_W'(WIDTH - 1));

    div_step #(
        .WIDTH(WIDTH)
    ) uStep (
        .t       (t),
        .divisor (divisorReg),
        .remNext (remNext),
        .qBit    (qBit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = (B != '0) ? CALC : DONE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (lastStep) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration registers and result latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qReg       <= '0;
            divisorReg <= '0;
            remReg     <= '0;
            stepCnt    <= '0;
            Quot       <= '0;
            Rem        <= '0;
            dz         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (B != '0) begin
                            qReg       <= A;
                            divisorReg <= B;
                            remReg     <= '0;
                            stepCnt    <= '0;
                        end else begin
                            Quot <= '1;
                            Rem  <= A;
                            dz   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    remReg  <= remNext;
                    qReg    <= {qReg[WIDTH-2:0], qBit};
                    stepCnt <= stepCnt + 1'b1;
                    if (lastStep) begin
                        Quot <= {qReg[WIDTH-2:0], qBit};
                        Rem  <= remNext[WIDTH-1:0];
                        dz   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider for the 8-bit mini CPU datapath; the inverse of the combinational adder.
- Each cycle performs one shift-and-trial-subtract step, producing one quotient bit.
- Sits beside the adder in the ALU; the control unit drives it with a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (CPU word).

Ports:
- clk    input   1      system clock, rising edge
- rst_n  input   1      synchronous active-low reset
- start  input   1      request a divide; sampled only in IDLE
- A      input   WIDTH  dividend; sampled with start
- B      input   WIDTH  divisor; sampled with start
- busy   output  1      high while in CALC
- done   output  1      one-cycle pulse; results valid
- Quot   output  WIDTH  quotient
- Rem    output  WIDTH  remainder
- dz     output  1      divide-by-zero flag for the last operation

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - Reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
  - Reset values: state=IDLE, busy=0, done=0, Quot=0, Rem=0, dz=0, all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1 and B!=0: latch A into the quotient shift register and B into the divisor register; clear the partial remainder (WIDTH+1 bits) and the step counter; go to CALC.
  - On an edge with start=1 and B==0: go to DONE with Quot=all-ones, Rem=A, dz=1. Latency is 1 edge.
- CALC, one restoring step per edge:
  - Form t = {rem[WIDTH-1:0], q[WIDTH-1]}.
  - Compute d = t - {1'b0, divisor} at WIDTH+1 bits.
  - If no borrow (d[WIDTH]==0): rem=d, shift q left with LSB=1.
  - Otherwise: rem=t, shift q left with LSB=0.
  - The counter increments each step. The edge that completes step WIDTH writes Quot=q and Rem=rem[WIDTH-1:0], sets dz=0, and goes to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- Latency: start sampled at edge k; done is high in the cycle after edge k+WIDTH (k+8 by default). Throughput is one divide per WIDTH+2 cycles.
- busy=1 only in CALC; done=1 only in DONE. The two are never high together.
- Quot, Rem and dz hold their last values until the next operation completes. They do not change during CALC.
- start in CALC or DONE is ignored; it is neither queued nor does it restart. A and B changing during CALC have no effect.
- A=0 gives Quot=0, Rem=0. B=1 gives Quot=A, Rem=0. A<B gives Quot=0, Rem=A.
- The partial remainder never exceeds WIDTH+1 bits; there is no other overflow case.
- rst_n low mid-CALC aborts the operation: next cycle is IDLE, outputs at reset values, no done pulse.

Decomposition:
- Shared package alu_pkg:
  - WIDTH default constant.
  - state typedef {IDLE, CALC, DONE}.
  - Step counter width, $clog2(WIDTH)+1.
- One natural sub-module, div_step: combinational trial subtract.
  - Inputs: t (WIDTH+1 bits), divisor (WIDTH bits).
  - Outputs: next remainder (WIDTH+1 bits), quotient bit (1 bit).
  - Instantiated once inside seq_divider.

Test Plan:
- Reset, then start with A=100, B=7 -> done pulses exactly 9 cycles after the start edge; Quot=14, Rem=2, dz=0; busy high for 8 cycles.
- A=255, B=1 -> Quot=255, Rem=0. A=5, B=9 -> Quot=0, Rem=5. A=0, B=3 -> Quot=0, Rem=0. Each case takes the same latency.
- A=42, B=0 -> done the cycle after the start edge; Quot=8'hFF, Rem=42, dz=1, busy never high. A following 10/3 clears dz and gives Quot=3, Rem=1.
- Start 200/13, then pulse start with A=9, B=2 during CALC and during DONE -> only one done pulse; Quot=15, Rem=5; outputs remain stable until the next start.
- Start 77/5, drive rst_n low at step 4 -> outputs 0, state IDLE, no done. Restart 77/5 -> Quot=15, Rem=2.
- Random sweep over all A, B in 0..255 against the reference model A/B, A%B (B=0 handled as above) -> zero mismatches.
